fighter_action_fsm: RTL and testbench

FIGHTER_ACTION_FSM -- requirements
Module: fighter_action_fsm

---
 rtl/fighter_action_fsm.sv | 152 +++++++++++++++
 tb/tb_fighter_action_fsm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fighter_action_fsm.sv
// Fighter action controller: turns edge-detected HID key presses into
// frame-timed punch / jump / recover actions for the sprite selector.
module fighter_action_fsm #(
    parameter logic [7:0]  KEY_PUNCH      = 8'h0E,
    parameter logic [7:0]  KEY_JUMP       = 8'h1A,
    parameter int unsigned PUNCH_FRAMES   = 12,
    parameter int unsigned JUMP_FRAMES    = 30,
    parameter int unsigned RECOVER_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic       punch,
    output logic       jump,
    output logic       busy
);

    localparam logic [5:0] P_LD = 6'(PUNCH_FRAMES);
    localparam logic [5:0] J_LD = 6'(JUMP_FRAMES);
    localparam logic [5:0] R_LD = 6'(RECOVER_FRAMES);

    typedef enum logic [2:0] {
        IDLE,
        PUNCH,
        JUMP,
        JUMP_PUNCH,
        RECOVER
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] pcnt_q, pcnt_d;
    logic [5:0] jcnt_q, jcnt_d;
    logic [5:0] rcnt_q, rcnt_d;
    logic       air_used_q, air_used_d;
    logic       prev_p_q, prev_p_d;
    logic       prev_j_q, prev_j_d;
    logic       punch_q, punch_d;
    logic       jump_q, jump_d;
    logic       busy_q, busy_d;

    logic       is_p, is_j;
    logic       punch_press, jump_press;
    logic [5:0] pdec, jdec, rdec;

    // Key press edge detection and frame-tick counter decrements (floor 0)
    always_comb begin
        is_p        = (keycode == KEY_PUNCH);
        is_j        = (keycode == KEY_JUMP);
        punch_press = is_p & ~prev_p_q;
        jump_press  = is_j & ~prev_j_q;
        prev_p_d    = is_p;
        prev_j_d    = is_j;
        pdec = (frame_tick && pcnt_q != 6'd0) ? pcnt_q - 6'd1 : pcnt_q;
        jdec = (frame_tick && jcnt_q != 6'd0) ? jcnt_q - 6'd1 : jcnt_q;
        rdec = (frame_tick && rcnt_q != 6'd0) ? rcnt_q - 6'd1 : rcnt_q;
    end

    // Next-state, counter loads (loads win over decrement) and output decode
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pdec;
        jcnt_d     = jdec;
        rcnt_d     = rdec;
        air_used_d = air_used_q;
        unique case (state_q)
            IDLE: begin
                if (punch_press && jump_press) begin
                    state_d    = JUMP_PUNCH;
                    pcnt_d     = P_LD;
                    jcnt_d     = J_LD;
                    air_used_d = 1'b1;
                end else if (punch_press) begin
                    state_d = PUNCH;
                    pcnt_d  = P_LD;
                end else if (jump_press) begin
                    state_d    = JUMP;
                    jcnt_d     = J_LD;
                    air_used_d = 1'b0;
                end
            end
            PUNCH: begin
                if (pdec == 6'd0) begin
                    state_d = RECOVER;
                    rcnt_d  = R_LD;
                end
            end
            JUMP: begin
                if (jdec == 6'd0) begin
                    state_d = IDLE;
                end else if (punch_press && !air_used_q) begin
                    state_d    = JUMP_PUNCH;
                    pcnt_d     = P_LD;
                    air_used_d = 1'b1;
                end
            end
            JUMP_PUNCH: begin
                if (pdec == 6'd0 && jdec == 6'd0) begin
                    state_d = RECOVER;
                    rcnt_d  = R_LD;
                end else if (pdec == 6'd0) begin
                    state_d = JUMP;
                end else if (jdec == 6'd0) begin
                    state_d = PUNCH;
                end
            end
            RECOVER: begin
                if (rdec == 6'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        punch_d = (state_d == PUNCH) || (state_d == JUMP_PUNCH);
        jump_d  = (state_d == JUMP) || (state_d == JUMP_PUNCH);
        busy_d  = (state_d != IDLE);
    end

    // State, counters and registered outputs; key history resets high
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            pcnt_q     <= 6'd0;
            jcnt_q     <= 6'd0;
            rcnt_q     <= 6'd0;
            air_used_q <= 1'b0;
            prev_p_q   <= 1'b1;
            prev_j_q   <= 1'b1;
            punch_q    <= 1'b0;
            jump_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            jcnt_q     <= jcnt_d;
            rcnt_q     <= rcnt_d;
            air_used_q <= air_used_d;
            prev_p_q   <= prev_p_d;
            prev_j_q   <= prev_j_d;
            punch_q    <= punch_d;
            jump_q     <= jump_d;
            busy_q     <= busy_d;
        end
    end

    assign punch = punch_q;
    assign jump  = jump_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Directed bench for fighter_action_fsm: per-cycle expected {punch,jump,busy}
// is queued with the stimulus and checked one edge later.
module tb_fighter_action_fsm;

    localparam logic [7:0] KP = 8'h0E;
    localparam logic [7:0] KJ = 8'h1A;
    localparam logic [7:0] KN = 8'h00;

    localparam logic [2:0] E_I  = 3'b000;
    localparam logic [2:0] E_P  = 3'b101;
    localparam logic [2:0] E_J  = 3'b011;
    localparam logic [2:0] E_JP = 3'b111;
    localparam logic [2:0] E_R  = 3'b001;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       frame_tick = 1'b0;
    logic       punch, jump, busy;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_q[$];
    string      tag_q[$];

    fighter_action_fsm dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .keycode   (keycode),
        .frame_tick(frame_tick),
        .punch     (punch),
        .jump      (jump),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [2:0] obs,
                         input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got pjb=%b exp pjb=%b", tag, obs, exp);
        end
    endtask

    task automatic cy(input string tag, input logic [7:0] k, input logic t,
                      input logic [2:0] e);
        string      tg;
        logic [2:0] ex;
        keycode    = k;
        frame_tick = t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clk);
        #1;
        tg = tag_q.pop_front();
        ex = exp_q.pop_front();
        check(tg, {punch, jump, busy}, ex);
    endtask

    task automatic run(input string tag, input int n, input logic [7:0] k,
                       input logic t, input logic [2:0] e);
        for (int i = 0; i < n; i++) cy(tag, k, t, e);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        check("reset", {punch, jump, busy}, E_I);
        Reset_n = 1'b1;
        cy("idle", KN, 1'b1, E_I);

        // ground punch, 12 frames + 4 recover
        cy("gp_press", KP, 1'b0, E_P);
        run("gp_act", 6, KN, 1'b1, E_P);
        cy("gp_notick", KN, 1'b0, E_P);
        run("gp_act2", 5, KN, 1'b1, E_P);
        cy("gp_end", KN, 1'b1, E_R);
        cy("gp_rec1", KN, 1'b1, E_R);
        cy("gp_rec_press", KP, 1'b0, E_R);
        run("gp_rec2", 2, KN, 1'b1, E_R);
        cy("gp_idle", KN, 1'b1, E_I);
        cy("gp_idle2", KN, 1'b0, E_I);

        // jump with air punch after 5 ticks
        cy("ja_press", KJ, 1'b0, E_J);
        run("ja_up", 5, KN, 1'b1, E_J);
        cy("ja_punch", KP, 1'b0, E_JP);
        run("ja_both", 11, KN, 1'b1, E_JP);
        cy("ja_pend", KN, 1'b1, E_J);
        cy("ja_repunch", KP, 1'b0, E_J);
        cy("ja_rel", KN, 1'b0, E_J);
        cy("ja_rejump", KJ, 1'b0, E_J);
        cy("ja_rel2", KN, 1'b0, E_J);
        run("ja_fall", 12, KN, 1'b1, E_J);
        cy("ja_land", KN, 1'b1, E_I);

        // landing mid-punch
        cy("lm_press", KJ, 1'b0, E_J);
        run("lm_up", 25, KN, 1'b1, E_J);
        cy("lm_punch", KP, 1'b0, E_JP);
        run("lm_both", 4, KN, 1'b1, E_JP);
        cy("lm_land", KN, 1'b1, E_P);
        run("lm_ground", 6, KN, 1'b1, E_P);
        cy("lm_pend", KN, 1'b1, E_R);
        run("lm_rec", 2, KN, 1'b1, E_R);
        cy("lm_rec_last", KN, 1'b1, E_R);
        cy("lm_idle", KN, 1'b1, E_I);

        // held punch key: one action, no retrigger until released
        cy("hk_press", KP, 1'b0, E_P);
        run("hk_act", 11, KP, 1'b1, E_P);
        cy("hk_pend", KP, 1'b1, E_R);
        run("hk_rec", 3, KP, 1'b1, E_R);
        cy("hk_idle", KP, 1'b1, E_I);
        run("hk_hold", 8, KP, 1'b1, E_I);
        cy("hk_rel", KN, 1'b0, E_I);

        // press coincident with frame tick: full 12 frames
        cy("ct_press", KP, 1'b1, E_P);
        run("ct_act", 11, KN, 1'b1, E_P);
        cy("ct_pend", KN, 1'b1, E_R);
        run("ct_rec", 3, KN, 1'b1, E_R);
        cy("ct_idle", KN, 1'b1, E_I);

        // air punch on a tick: jump counter still decrements
        cy("ad_press", KJ, 1'b0, E_J);
        run("ad_up", 28, KN, 1'b1, E_J);
        cy("ad_punch", KP, 1'b1, E_JP);
        cy("ad_land", KN, 1'b1, E_P);
        run("ad_ground", 10, KN, 1'b1, E_P);
        cy("ad_pend", KN, 1'b1, E_R);
        run("ad_rec", 3, KN, 1'b1, E_R);
        cy("ad_idle", KN, 1'b1, E_I);

        // reset mid-jump with jump key held
        cy("rj_press", KJ, 1'b0, E_J);
        run("rj_hold", 2, KJ, 1'b1, E_J);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rj_async", {punch, jump, busy}, E_I);
        @(posedge Clk);
        #1;
        check("rj_inrst", {punch, jump, busy}, E_I);
        Reset_n = 1'b1;
        run("rj_held", 3, KJ, 1'b1, E_I);
        cy("rj_rel", KN, 1'b0, E_I);
        cy("rj_repress", KJ, 1'b0, E_J);
        cy("rj_up", KN, 1'b1, E_J);

        frame_tick = 1'b0;
        keycode    = KN;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
